// File: rtl/vga_frame_ctrl.sv
// Pixel-source arbiter for the VGA output path with a req/ack configuration
// port whose updates are deferred to the end-of-frame boundary.
module vga_frame_ctrl #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               src0_on,
  input  logic [2:0]         src0_rgb,
  input  logic               src1_on,
  input  logic [2:0]         src1_rgb,
  input  logic               cfg_req,
  input  logic [2:0]         cfg_en,
  input  logic [2:0]         cfg_bg,
  output logic               cfg_ack,
  output logic               cfg_busy,
  output logic [2:0]         rgb,
  output logic [1:0]         sel,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY, ACK} state_t;

  localparam logic [1:0] SEL_SRC0 = 2'd0;
  localparam logic [1:0] SEL_SRC1 = 2'd1;
  localparam logic [1:0] SEL_BG   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  state_t             state_q, state_d;
  logic [2:0]         en_q, en_d;
  logic [2:0]         bg_q, bg_d;
  logic [2:0]         pen_en_q, pen_en_d;
  logic [2:0]         pen_bg_q, pen_bg_d;
  logic [2:0]         rgb_q, rgb_d;
  logic [1:0]         sel_q, sel_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_end;

  assign frame_end = p_tick && (pixel_x == 10'(H_TOTAL - 1))
                            && (pixel_y == 10'(V_TOTAL - 1));

  // Arbitration reads the active config before any APPLY update on this edge.
  always_comb begin
    rgb_d = rgb_q;
    sel_d = sel_q;
    if (p_tick) begin
      if (!video_on) begin
        rgb_d = 3'b000;
        sel_d = SEL_NONE;
      end else if (en_q[0] && src0_on) begin
        rgb_d = src0_rgb;
        sel_d = SEL_SRC0;
      end else if (en_q[1] && src1_on) begin
        rgb_d = src1_rgb;
        sel_d = SEL_SRC1;
      end else if (en_q[2]) begin
        rgb_d = bg_q;
        sel_d = SEL_BG;
      end else begin
        rgb_d = 3'b000;
        sel_d = SEL_NONE;
      end
    end
  end

  assign frame_d = frame_end ? frame_q + FRAME_W'(1) : frame_q;

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    bg_d     = bg_q;
    pen_en_d = pen_en_q;
    pen_bg_d = pen_bg_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    unique case (state_q)
      // A frame_end coinciding with capture is not seen until PENDING.
      IDLE: if (cfg_req) begin
        pen_en_d = cfg_en;
        pen_bg_d = cfg_bg;
        busy_d   = 1'b1;
        state_d  = PENDING;
      end
      PENDING: if (frame_end) state_d = APPLY;
      APPLY: begin
        en_d    = pen_en_q;
        bg_d    = pen_bg_q;
        busy_d  = 1'b0;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: if (!cfg_req) begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 3'b111;
      bg_q     <= 3'b000;
      pen_en_q <= 3'b000;
      pen_bg_q <= 3'b000;
      rgb_q    <= 3'b000;
      sel_q    <= SEL_NONE;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      bg_q     <= bg_d;
      pen_en_q <= pen_en_d;
      pen_bg_q <= pen_bg_d;
      rgb_q    <= rgb_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
    end
  end

  assign rgb       = rgb_q;
  assign sel       = sel_q;
  assign cfg_ack   = ack_q;
  assign cfg_busy  = busy_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl: vector table, handshake/boundary sequences and a
// random phase checked against a transaction-level model.
module tb_vga_frame_ctrl;
  localparam int H = 800;
  localparam int V = 525;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic       src0_on, src1_on;
  logic [2:0] src0_rgb, src1_rgb;
  logic       cfg_req;
  logic [2:0] cfg_en, cfg_bg;
  logic       cfg_ack, cfg_busy;
  logic [2:0] rgb;
  logic [1:0] sel;
  logic [7:0] frame_cnt;

  vga_frame_ctrl #(.H_TOTAL(H), .V_TOTAL(V), .FRAME_W(8)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .src0_on(src0_on), .src0_rgb(src0_rgb), .src1_on(src1_on), .src1_rgb(src1_rgb),
    .cfg_req(cfg_req), .cfg_en(cfg_en), .cfg_bg(cfg_bg),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .rgb(rgb), .sel(sel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: active/pending config, expected outputs, and an "apply on next
  // edge" flag raised by the frame boundary that ends a pending wait.
  logic [2:0] m_en, m_bg, m_pen_en, m_pen_bg;
  logic [2:0] e_rgb;
  logic [1:0] e_sel;
  logic       e_ack, e_busy, apply_now;
  logic [7:0] e_cnt;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_en = 3'b111; m_bg = 3'b000; m_pen_en = 3'b000; m_pen_bg = 3'b000;
    e_rgb = 3'b000; e_sel = 2'd3; e_ack = 1'b0; e_busy = 1'b0;
    e_cnt = 8'd0; apply_now = 1'b0;
  endfunction

  task automatic step();
    logic fe;
    @(posedge clk);
    fe = p_tick && pixel_x == 10'(H - 1) && pixel_y == 10'(V - 1);
    if (reset) model_reset();
    else begin
      if (p_tick) begin
        if (!video_on)                  begin e_rgb = 3'b000;   e_sel = 2'd3; end
        else if (m_en[0] && src0_on)    begin e_rgb = src0_rgb; e_sel = 2'd0; end
        else if (m_en[1] && src1_on)    begin e_rgb = src1_rgb; e_sel = 2'd1; end
        else if (m_en[2])               begin e_rgb = m_bg;     e_sel = 2'd2; end
        else                            begin e_rgb = 3'b000;   e_sel = 2'd3; end
      end
      if (fe) e_cnt = e_cnt + 8'd1;
      if (apply_now) begin
        m_en = m_pen_en; m_bg = m_pen_bg;
        e_busy = 1'b0; e_ack = 1'b1; apply_now = 1'b0;
      end else if (e_busy && fe) apply_now = 1'b1;
      else if (!e_busy && !e_ack && cfg_req) begin
        m_pen_en = cfg_en; m_pen_bg = cfg_bg; e_busy = 1'b1;
      end else if (e_ack && !cfg_req) e_ack = 1'b0;
    end
    #1;
    chk("m_rgb", 8'(rgb), 8'(e_rgb));
    chk("m_sel", 8'(sel), 8'(e_sel));
    chk("m_ack", 8'(cfg_ack), 8'(e_ack));
    chk("m_busy", 8'(cfg_busy), 8'(e_busy));
    chk("m_cnt", frame_cnt, e_cnt);
  endtask

  task automatic do_cfg(input logic [2:0] en, input logic [2:0] bg);
    p_tick = 0; cfg_req = 1; cfg_en = en; cfg_bg = bg; pixel_x = 100; pixel_y = 200;
    step();
    chk("cfg_busy_set", 8'(cfg_busy), 8'd1);
    cfg_en = ~en; cfg_bg = ~bg;
    p_tick = 1;
    repeat (3) begin
      step();
      chk("cfg_busy_wait", 8'(cfg_busy), 8'd1);
      chk("cfg_ack_wait", 8'(cfg_ack), 8'd0);
    end
    pixel_x = 10'(H - 1); pixel_y = 10'(V - 1);
    step();
    p_tick = 0; pixel_x = 0; pixel_y = 0;
    step();
    chk("cfg_ack_rise", 8'(cfg_ack), 8'd1);
    chk("cfg_busy_clr", 8'(cfg_busy), 8'd0);
    step();
    chk("cfg_ack_hold", 8'(cfg_ack), 8'd1);
    cfg_req = 0;
    step();
    chk("cfg_ack_drop", 8'(cfg_ack), 8'd0);
  endtask

  typedef struct {
    logic pt, von, s0, s1;
    logic [2:0] c0, c1, er;
    logic [1:0] es;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [7:0] prev;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 3'b010, 3'b100, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'b010, 3'b010, 2'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010, 3'b001, 2'd2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 3'b010, 3'b000, 2'd3};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 3'b111, 2'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b101, 3'b111, 2'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 2'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b101, 3'b101, 2'd1};

    reset = 1; p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
    src0_on = 0; src1_on = 0; src0_rgb = 0; src1_rgb = 0;
    cfg_req = 0; cfg_en = 0; cfg_bg = 0;
    model_reset();
    step(); step();
    reset = 0;

    // Default config after reset: background enabled, colour 000.
    p_tick = 1; video_on = 1; pixel_x = 10; pixel_y = 10;
    step();
    chk("rst_dflt_rgb", 8'(rgb), 8'd0);
    chk("rst_dflt_sel", 8'(sel), 8'd2);

    do_cfg(3'b111, 3'b001);
    foreach (tbl[i]) begin
      p_tick = tbl[i].pt; video_on = tbl[i].von; pixel_x = 10; pixel_y = 10;
      src0_on = tbl[i].s0; src1_on = tbl[i].s1; src0_rgb = tbl[i].c0; src1_rgb = tbl[i].c1;
      step();
      chk($sformatf("tbl%0d_rgb", i), 8'(rgb), 8'(tbl[i].er));
      chk($sformatf("tbl%0d_sel", i), 8'(sel), 8'(tbl[i].es));
    end

    // src0 disabled by the new config; pixel (0,0) shows the new background.
    do_cfg(3'b110, 3'b011);
    p_tick = 1; video_on = 1; pixel_x = 0; pixel_y = 0;
    src0_on = 1; src0_rgb = 3'b100; src1_on = 0;
    step();
    chk("new_cfg_rgb", 8'(rgb), 8'b011);
    chk("new_cfg_sel", 8'(sel), 8'd2);

    do_cfg(3'b000, 3'b101);
    p_tick = 1; video_on = 1; src0_on = 1; src1_on = 1;
    step();
    chk("all_off_sel", 8'(sel), 8'd3);
    chk("all_off_rgb", 8'(rgb), 8'd0);

    // Request lands on the frame_end cycle: must wait for the next boundary.
    src0_on = 0; src1_on = 0;
    cfg_req = 1; cfg_en = 3'b111; cfg_bg = 3'b110;
    p_tick = 1; pixel_x = 10'(H - 1); pixel_y = 10'(V - 1);
    prev = e_cnt;
    step();
    chk("coll_cnt", frame_cnt, prev + 8'd1);
    chk("coll_busy", 8'(cfg_busy), 8'd1);
    pixel_x = 5; pixel_y = 5;
    repeat (3) begin
      step();
      chk("coll_noapply_sel", 8'(sel), 8'd3);
      chk("coll_busy_hold", 8'(cfg_busy), 8'd1);
    end
    pixel_x = 10'(H - 1); pixel_y = 10'(V - 1);
    step();
    p_tick = 0; pixel_x = 0; pixel_y = 0;
    step();
    chk("coll_ack", 8'(cfg_ack), 8'd1);
    p_tick = 1;
    step();
    chk("coll_apply_rgb", 8'(rgb), 8'b110);
    chk("coll_apply_sel", 8'(sel), 8'd2);
    cfg_req = 0;
    step();
    chk("coll_ack_drop", 8'(cfg_ack), 8'd0);

    // Frame counter wrap: every cycle is a frame_end.
    pixel_x = 10'(H - 1); pixel_y = 10'(V - 1); p_tick = 1;
    for (int i = 0; i < 260; i++) begin
      prev = e_cnt;
      step();
      if (prev == 8'd255) chk("cnt_wrap", frame_cnt, 8'd0);
    end

    // Reset while a config is pending.
    cfg_req = 1; cfg_en = 3'b001; cfg_bg = 3'b111; p_tick = 0; pixel_x = 5; pixel_y = 5;
    step();
    chk("pend_busy", 8'(cfg_busy), 8'd1);
    p_tick = 1; video_on = 1; src0_on = 1; src0_rgb = 3'b101;
    step();
    chk("pre_rst_rgb", 8'(rgb), 8'b101);
    reset = 1;
    #1;
    chk("async_rst_rgb", 8'(rgb), 8'd0);
    chk("async_rst_sel", 8'(sel), 8'd3);
    chk("async_rst_busy", 8'(cfg_busy), 8'd0);
    chk("async_rst_ack", 8'(cfg_ack), 8'd0);
    chk("async_rst_cnt", frame_cnt, 8'd0);
    model_reset();
    step();
    reset = 0; cfg_req = 0; src0_on = 0; src1_on = 0;
    step();
    chk("post_rst_rgb", 8'(rgb), 8'd0);
    chk("post_rst_sel", 8'(sel), 8'd2);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      p_tick   = ($urandom_range(0, 3) != 0);
      video_on = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        pixel_x = 10'(H - 1); pixel_y = 10'(V - 1);
      end else begin
        pixel_x = 10'($urandom_range(0, H - 1));
        pixel_y = 10'($urandom_range(0, V - 1));
      end
      src0_on = 1'($urandom); src1_on = 1'($urandom);
      src0_rgb = 3'($urandom); src1_rgb = 3'($urandom);
      cfg_en = 3'($urandom); cfg_bg = 3'($urandom);
      if ($urandom_range(0, 9) == 0) cfg_req = ~cfg_req;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
